eda_window_ram: RTL and testbench

EDA_WINDOW_RAM -- requirements
Module: eda_window_ram

---
 rtl/eda_window_ram.sv | 259 +++++++++++++++++++++++++
 tb/tb_eda_window_ram.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eda_window_ram.sv
`default_nettype none
// ============================================================================
// Module      : eda_window_ram
// Description : Image pixel RAM with a (2R+1)x(2R+1) neighbourhood read port.
//               Windows are requested externally or by an internal raster
//               scan and delivered through a one-deep valid/ready register
//               stage, with zero-pad or replicate-edge border handling.
// Revision    : 1.0  initial release
// ============================================================================
module eda_window_ram #(
    parameter int M           = 64,
    parameter int N           = 64,
    parameter int PIXEL_WIDTH = 8,
    parameter int RADIUS      = 1,
    parameter int I_WIDTH     = $clog2(M),
    parameter int J_WIDTH     = $clog2(N),
    parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH
) (
    input  logic                                                 clk,
    input  logic                                                 reset_n,
    input  logic                                                 write_en,
    input  logic [ADDR_WIDTH-1:0]                                wr_addr,
    input  logic [PIXEL_WIDTH-1:0]                               pixel_in,
    input  logic                                                 req_valid,
    input  logic [ADDR_WIDTH-1:0]                                center_addr,
    output logic                                                 req_ready,
    input  logic [1:0]                                           border_mode,
    input  logic                                                 scan_start,
    output logic                                                 scan_busy,
    output logic                                                 scan_done,
    output logic                                                 win_valid,
    input  logic                                                 win_ready,
    output logic                                                 win_last,
    output logic [(2*RADIUS+1)*(2*RADIUS+1)*PIXEL_WIDTH-1:0]     window_values,
    output logic [(2*RADIUS+1)*(2*RADIUS+1)-1:0]                 neigh_valid,
    output logic [ADDR_WIDTH-1:0]                                win_center,
    output logic                                                 addr_err
);

    localparam int D    = 2 * RADIUS + 1;
    localparam int K    = D * D;
    localparam int PW   = PIXEL_WIDTH;
    // Array index widths; the address fields may be wider than the array needs.
    localparam int AI_W = (M > 1) ? $clog2(M) : 1;
    localparam int AJ_W = (N > 1) ? $clog2(N) : 1;
    // Signed neighbour index width: one sign bit plus one guard bit so that
    // centre +/- RADIUS never wraps even when the centre field is all ones.
    localparam int WMAX = (I_WIDTH > J_WIDTH) ? I_WIDTH : J_WIDTH;
    localparam int SW   = WMAX + 2;

    localparam logic [I_WIDTH:0]        M_U    = (I_WIDTH+1)'(M);
    localparam logic [J_WIDTH:0]        N_U    = (J_WIDTH+1)'(N);
    localparam logic signed [SW-1:0]    M_S    = SW'(M);
    localparam logic signed [SW-1:0]    N_S    = SW'(N);
    localparam logic [I_WIDTH-1:0]      I_LAST = I_WIDTH'(M - 1);
    localparam logic [J_WIDTH-1:0]      J_LAST = J_WIDTH'(N - 1);
    localparam logic [AI_W-1:0]         I_MAXA = AI_W'(M - 1);
    localparam logic [AJ_W-1:0]         J_MAXA = AJ_W'(N - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Image storage (not reset)
    // ------------------------------------------------------------------------
    logic [PW-1:0] img [M][N];

    logic [I_WIDTH-1:0] wr_i;
    logic [J_WIDTH-1:0] wr_j;
    logic               wr_in_range;

    assign wr_i        = wr_addr[ADDR_WIDTH-1:J_WIDTH];
    assign wr_j        = wr_addr[J_WIDTH-1:0];
    assign wr_in_range = ({1'b0, wr_i} < M_U) && ({1'b0, wr_j} < N_U);

    // Pixel write; out-of-range coordinates are dropped.
    always_ff @(posedge clk) begin
        if (write_en && wr_in_range) begin
            img[wr_i[AI_W-1:0]][wr_j[AJ_W-1:0]] <= pixel_in;
        end
    end

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [I_WIDTH-1:0]     scan_i_q, scan_i_d;
    logic [J_WIDTH-1:0]     scan_j_q, scan_j_d;
    logic                   scan_busy_q, scan_busy_d;
    logic                   scan_done_q, scan_done_d;
    logic                   win_valid_q, win_valid_d;
    logic                   win_last_q, win_last_d;
    logic                   addr_err_q, addr_err_d;
    logic [K-1:0]           neigh_valid_q, neigh_valid_d;
    logic [K*PW-1:0]        window_q, window_d;
    logic [ADDR_WIDTH-1:0]  win_center_q, win_center_d;

    // ------------------------------------------------------------------------
    // Request selection: the scan counter owns the window port while scanning
    // ------------------------------------------------------------------------
    logic                   in_scan;
    logic                   slot_free;
    logic                   req_ready_w;
    logic                   accept;
    logic [ADDR_WIDTH-1:0]  sel_center;
    logic [I_WIDTH-1:0]     sel_i;
    logic [J_WIDTH-1:0]     sel_j;
    logic                   centre_ok;
    logic                   replicate;
    logic                   last_xfer;

    assign in_scan     = (state_q == SCAN);
    assign slot_free   = !win_valid_q || win_ready;
    assign req_ready_w = slot_free && !scan_busy_q;
    assign accept      = in_scan ? slot_free : (req_valid && req_ready_w);
    assign sel_center  = in_scan ? {scan_i_q, scan_j_q} : center_addr;
    assign sel_i       = sel_center[ADDR_WIDTH-1:J_WIDTH];
    assign sel_j       = sel_center[J_WIDTH-1:0];
    assign centre_ok   = ({1'b0, sel_i} < M_U) && ({1'b0, sel_j} < N_U);
    assign replicate   = (border_mode == 2'd1);
    assign last_xfer   = win_valid_q && win_ready && win_last_q;

    // ------------------------------------------------------------------------
    // Neighbourhood gather: one slice per window offset, upper-left in MSBs
    // ------------------------------------------------------------------------
    logic [K*PW-1:0] win_vals_w;
    logic [K-1:0]    nv_w;

    for (genvar s = 0; s < K; s++) begin : g_slice
        localparam int OFS = K - 1 - s;
        localparam int DI  = (OFS / D) - RADIUS;
        localparam int DJ  = (OFS % D) - RADIUS;
        localparam logic signed [SW-1:0] DI_S = SW'(DI);
        localparam logic signed [SW-1:0] DJ_S = SW'(DJ);

        logic signed [SW-1:0] ni;
        logic signed [SW-1:0] nj;
        logic                 in_i;
        logic                 in_j;
        logic [AI_W-1:0]      ci;
        logic [AJ_W-1:0]      cj;
        logic [PW-1:0]        pix;

        assign ni   = $signed({{(SW-I_WIDTH){1'b0}}, sel_i}) + DI_S;
        assign nj   = $signed({{(SW-J_WIDTH){1'b0}}, sel_j}) + DJ_S;
        assign in_i = !ni[SW-1] && (ni < M_S);
        assign in_j = !nj[SW-1] && (nj < N_S);
        // Clamped coordinates double as the read index for in-range pixels.
        assign ci   = ni[SW-1] ? '0 : (in_i ? ni[AI_W-1:0] : I_MAXA);
        assign cj   = nj[SW-1] ? '0 : (in_j ? nj[AJ_W-1:0] : J_MAXA);
        assign pix  = img[ci][cj];

        assign win_vals_w[s*PW +: PW] =
            (centre_ok && ((in_i && in_j) || replicate)) ? pix : '0;
        assign nv_w[s] = centre_ok && in_i && in_j;
    end

    // ------------------------------------------------------------------------
    // Next-state: output stage load/drain, scan counter and FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        scan_i_d      = scan_i_q;
        scan_j_d      = scan_j_q;
        scan_busy_d   = scan_busy_q;
        scan_done_d   = last_xfer;
        win_valid_d   = win_valid_q;
        win_last_d    = win_last_q;
        addr_err_d    = addr_err_q;
        neigh_valid_d = neigh_valid_q;
        window_d      = window_q;
        win_center_d  = win_center_q;

        if (accept) begin
            win_valid_d   = 1'b1;
            window_d      = win_vals_w;
            neigh_valid_d = nv_w;
            win_center_d  = sel_center;
            addr_err_d    = !centre_ok;
            win_last_d    = in_scan && (scan_i_q == I_LAST) && (scan_j_q == J_LAST);
        end else if (win_ready) begin
            win_valid_d   = 1'b0;
        end

        if (last_xfer) begin
            scan_busy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d     = SCAN;
                    scan_i_d    = '0;
                    scan_j_d    = '0;
                    scan_busy_d = 1'b1;
                end
            end
            SCAN: begin
                if (accept) begin
                    if (scan_j_q == J_LAST) begin
                        scan_j_d = '0;
                        if (scan_i_q == I_LAST) begin
                            scan_i_d = '0;
                            state_d  = IDLE;
                        end else begin
                            scan_i_d = scan_i_q + 1'b1;
                        end
                    end else begin
                        scan_j_d = scan_j_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous clear of everything except the image.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            scan_i_q      <= '0;
            scan_j_q      <= '0;
            scan_busy_q   <= 1'b0;
            scan_done_q   <= 1'b0;
            win_valid_q   <= 1'b0;
            win_last_q    <= 1'b0;
            addr_err_q    <= 1'b0;
            neigh_valid_q <= '0;
            window_q      <= '0;
            win_center_q  <= '0;
        end else begin
            state_q       <= state_d;
            scan_i_q      <= scan_i_d;
            scan_j_q      <= scan_j_d;
            scan_busy_q   <= scan_busy_d;
            scan_done_q   <= scan_done_d;
            win_valid_q   <= win_valid_d;
            win_last_q    <= win_last_d;
            addr_err_q    <= addr_err_d;
            neigh_valid_q <= neigh_valid_d;
            window_q      <= window_d;
            win_center_q  <= win_center_d;
        end
    end

    assign req_ready     = req_ready_w;
    assign scan_busy     = scan_busy_q;
    assign scan_done     = scan_done_q;
    assign win_valid     = win_valid_q;
    assign win_last      = win_last_q;
    assign addr_err      = addr_err_q;
    assign neigh_valid   = neigh_valid_q;
    assign window_values = window_q;
    assign win_center    = win_center_q;

endmodule
`default_nettype wire

// File: tb/tb_eda_window_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_eda_window_ram
// Description : Self-checking bench for eda_window_ram (4x4 image, radius 1,
//               3-bit row field so out-of-range centres are expressible).
// Revision    : 1.0  initial release
// ============================================================================
module tb_eda_window_ram;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int PW = 8;
    localparam int R  = 1;
    localparam int IW = 3;
    localparam int JW = 2;
    localparam int AW = IW + JW;
    localparam int D  = 2 * R + 1;
    localparam int K  = D * D;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            write_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [PW-1:0]   pixel_in = '0;
    logic            req_valid = 1'b0;
    logic [AW-1:0]   center_addr = '0;
    logic            req_ready;
    logic [1:0]      border_mode = 2'd0;
    logic            scan_start = 1'b0;
    logic            scan_busy;
    logic            scan_done;
    logic            win_valid;
    logic            win_ready = 1'b1;
    logic            win_last;
    logic [K*PW-1:0] window_values;
    logic [K-1:0]    neigh_valid;
    logic [AW-1:0]   win_center;
    logic            addr_err;

    eda_window_ram #(
        .M(M), .N(N), .PIXEL_WIDTH(PW), .RADIUS(R), .I_WIDTH(IW), .J_WIDTH(JW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .write_en(write_en), .wr_addr(wr_addr), .pixel_in(pixel_in),
        .req_valid(req_valid), .center_addr(center_addr), .req_ready(req_ready),
        .border_mode(border_mode), .scan_start(scan_start),
        .scan_busy(scan_busy), .scan_done(scan_done),
        .win_valid(win_valid), .win_ready(win_ready), .win_last(win_last),
        .window_values(window_values), .neigh_valid(neigh_valid),
        .win_center(win_center), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [PW-1:0]   mem [M][N];
    logic            m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_last = 1'b0, m_err = 1'b0;
    logic [K*PW-1:0] m_vals = '0;
    logic [K-1:0]    m_nv = '0;
    logic [AW-1:0]   m_center = '0;
    int              scan_q[$];
    logic [AW-1:0]   rx_center[$];
    logic            rx_last[$];
    int              done_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Window the specification describes for centre c (address {i,j}).
    function automatic void expect_win(input int c, input int mode,
                                       output logic [K*PW-1:0] vals,
                                       output logic [K-1:0] nv, output logic err);
        int i, j, ni, nj, ci, cj, s;
        bit inr;
        i = c / 4;
        j = c % 4;
        vals = '0;
        nv   = '0;
        err  = (i >= M) || (j >= N);
        if (!err) begin
            for (int di = -R; di <= R; di++) begin
                for (int dj = -R; dj <= R; dj++) begin
                    ni  = i + di;
                    nj  = j + dj;
                    s   = K - 1 - ((di + R) * D + (dj + R));
                    inr = (ni >= 0) && (ni < M) && (nj >= 0) && (nj < N);
                    nv[s] = inr;
                    ci = (ni < 0) ? 0 : ((ni > M - 1) ? M - 1 : ni);
                    cj = (nj < 0) ? 0 : ((nj > N - 1) ? N - 1 : nj);
                    if (inr || mode == 1) vals[s*PW +: PW] = mem[ci][cj];
                end
            end
        end
    endfunction

    // One clock: inputs are already driven; checks before and after the edge.
    task automatic cycle();
        logic            exp_ready, acc_ext, acc_int, xfer, start, scanning, n_last, er;
        logic [K*PW-1:0] v;
        logic [K-1:0]    nv;
        int              c;
        #1;
        scanning  = scan_q.size() > 0;
        exp_ready = (!m_valid || win_ready) && !m_busy;
        chk("req_ready", req_ready, exp_ready);
        if (win_valid && win_ready) begin
            rx_center.push_back(win_center);
            rx_last.push_back(win_last);
        end
        xfer    = m_valid && win_ready;
        start   = !scanning && scan_start;
        acc_int = scanning && (!m_valid || win_ready);
        acc_ext = !scanning && req_valid && exp_ready;
        n_last  = 1'b0;
        c       = int'(center_addr);
        if (acc_int) begin
            c      = scan_q.pop_front();
            n_last = (scan_q.size() == 0);
        end
        expect_win(c, int'(border_mode), v, nv, er);
        @(posedge clk);
        m_done = xfer && m_last;
        if (m_done) m_busy = 1'b0;
        if (start) begin
            m_busy = 1'b1;
            for (int a = 0; a < M * N; a++) scan_q.push_back((a / N) * 4 + (a % N));
        end
        if (acc_int || acc_ext) begin
            m_valid  = 1'b1;
            m_vals   = v;
            m_nv     = nv;
            m_err    = er;
            m_center = AW'(c);
            m_last   = n_last;
        end else if (win_ready) begin
            m_valid = 1'b0;
        end
        if (write_en && (int'(wr_addr[4:2]) < M)) mem[wr_addr[4:2]][wr_addr[1:0]] = pixel_in;
        @(negedge clk);
        chk("win_valid", win_valid, m_valid);
        chk("scan_busy", scan_busy, m_busy);
        chk("scan_done", scan_done, m_done);
        if (scan_done) done_cnt++;
        if (m_valid) begin
            chk("win_center", win_center, m_center);
            chk("win_last", win_last, m_last);
            chk("addr_err", addr_err, m_err);
            chk("neigh_valid", neigh_valid, m_nv);
            chk("window_values", window_values, m_vals);
        end
    endtask

    task automatic request(input int c, input int mode);
        req_valid   = 1'b1;
        center_addr = AW'(c);
        border_mode = 2'(mode);
        cycle();
        req_valid   = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_scan_busy", scan_busy, 1'b0);
        chk("rst_window", window_values, '0);
        reset_n = 1'b1;
        #1;
        chk("ready_after_reset", req_ready, 1'b1);
        @(negedge clk);

        // Load image 4i+j+1, plus one write to a row that does not exist.
        for (int a = 0; a < M * N; a++) begin
            write_en = 1'b1;
            wr_addr  = AW'((a / N) * 4 + (a % N));
            pixel_in = PW'(a + 1);
            cycle();
        end
        wr_addr  = 5'b10100;
        pixel_in = 8'hFF;
        cycle();
        write_en = 1'b0;

        // Zero-pad corner
        request(0, 0);
        chk("zp_values", window_values, 72'h000000000102000506);
        chk("zp_neigh", neigh_valid, 9'b000011011);
        // Replicate corner
        request(0, 1);
        chk("rep_values", window_values, 72'h010102010102050506);
        chk("rep_neigh", neigh_valid, 9'b000011011);
        cycle();

        // Backpressure on centre (2,2); a competing request must wait.
        request(10, 0);
        win_ready   = 1'b0;
        req_valid   = 1'b1;
        center_addr = AW'(3);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_req_ready", req_ready, 1'b0);
            cycle();
            chk("bp_hold_values", window_values, 72'h0607080A0B0C0E0F10);
            chk("bp_hold_valid", win_valid, 1'b1);
        end
        req_valid = 1'b0;
        win_ready = 1'b1;
        cycle();
        chk("bp_release", win_valid, 1'b0);

        // Read-before-write hazard on (1,1)
        write_en = 1'b1;
        wr_addr  = AW'(5);
        pixel_in = 8'hAA;
        req_valid   = 1'b1;
        center_addr = AW'(5);
        border_mode = 2'd0;
        cycle();
        write_en  = 1'b0;
        req_valid = 1'b0;
        chk("hazard_old", window_values[39:32], 8'd6);
        request(5, 0);
        chk("hazard_new", window_values[39:32], 8'hAA);

        // Out-of-range centre (4,0)
        request(16, 1);
        chk("err_flag", addr_err, 1'b1);
        chk("err_neigh", neigh_valid, '0);
        chk("err_values", window_values, '0);
        cycle();

        // Full scan with random backpressure
        rx_center.delete();
        rx_last.delete();
        done_cnt    = 0;
        scan_start  = 1'b1;
        border_mode = 2'd1;
        cycle();
        scan_start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            win_ready = 1'($urandom_range(0, 1));
            req_valid = 1'($urandom_range(0, 1));
            center_addr = AW'($urandom_range(0, 31));
            cycle();
            if (!m_busy && done_cnt > 0) break;
        end
        req_valid = 1'b0;
        win_ready = 1'b1;
        chk("scan_busy_end", scan_busy, 1'b0);
        chk("scan_count", rx_center.size(), 16);
        chk("scan_done_count", done_cnt, 1);
        for (int k = 0; k < rx_center.size() && k < 16; k++) begin
            chk("scan_order", rx_center[k], AW'(k));
            chk("scan_last_flag", rx_last[k], (k == 15));
        end

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            write_en    = ($urandom_range(0, 9) < 3);
            wr_addr     = AW'($urandom_range(0, 31));
            pixel_in    = PW'($urandom);
            req_valid   = ($urandom_range(0, 1) == 1);
            center_addr = AW'($urandom_range(0, 31));
            border_mode = 2'($urandom_range(0, 3));
            win_ready   = ($urandom_range(0, 9) < 7);
            scan_start  = ($urandom_range(0, 49) == 0);
            cycle();
        end
        write_en   = 1'b0;
        req_valid  = 1'b0;
        scan_start = 1'b0;
        win_ready  = 1'b1;
        for (int k = 0; k < 100 && m_busy; k++) cycle();
        chk("drain_busy", scan_busy, 1'b0);

        // Reset in the middle of a scan
        scan_start = 1'b1;
        cycle();
        scan_start = 1'b0;
        repeat (5) cycle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_win_valid", win_valid, 1'b0);
        chk("arst_scan_busy", scan_busy, 1'b0);
        chk("arst_scan_done", scan_done, 1'b0);
        chk("arst_win_last", win_last, 1'b0);
        chk("arst_addr_err", addr_err, 1'b0);
        chk("arst_neigh", neigh_valid, '0);
        chk("arst_window", window_values, '0);
        chk("arst_center", win_center, '0);
        m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_last = 1'b0;
        m_err = 1'b0; m_vals = '0; m_nv = '0; m_center = '0;
        scan_q.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_done", scan_done, 1'b0);
        end
        reset_n = 1'b1;
        #1;
        chk("ready_after_midscan_reset", req_ready, 1'b1);
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
